// File: rtl/multicycle_ctrl_if.sv
// Bundle of the instruction-memory, decode and execute handshake signals
// between the multicycle sequencer and its external units.
//   master: the sequencer (drives imem_addr, dec_*, ex_start, operands)
//   slave : memory / decode / execute side (drives imem_data, *_done and
//           the execute result fields)
// Parameters: XLEN datapath width, AW instruction address width.
interface multicycle_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 3
);
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_data;
  logic            dec_start;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_done;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic            ex_start;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic            ex_done;
  logic [4:0]      ex_rd;
  logic            ex_we;
  logic [XLEN-1:0] ex_result;
  logic            ex_branch;
  logic [XLEN-1:0] ex_target;

  modport master (
    output imem_addr, dec_start, dec_instr, dec_pc, ex_start, ex_rs1_val, ex_rs2_val,
    input  imem_data, dec_done, dec_rs1, dec_rs2, ex_done, ex_rd, ex_we, ex_result,
           ex_branch, ex_target
  );

  modport slave (
    input  imem_addr, dec_start, dec_instr, dec_pc, ex_start, ex_rs1_val, ex_rs2_val,
    output imem_data, dec_done, dec_rs1, dec_rs2, ex_done, ex_rd, ex_we, ex_result,
           ex_branch, ex_target
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> WB, owns the PC and the register file.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   run, step       continuous-run level / single-instruction pulse
//   bus (master)    imem address/data, decode and execute handshakes
//   pc_out          current PC (word index)
//   state_out       IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5 ERR=6
//   retired         completed WB count (wraps)
//   halted, error   high in HALT / ERR
//   dbg_raddr/rdata combinational register-file read port
module multicycle_ctrl #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 8,
  parameter int RESET_PC   = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                run,
  input  logic                step,
  multicycle_ctrl_if.master   bus,
  output logic [XLEN-1:0]     pc_out,
  output logic [2:0]          state_out,
  output logic [31:0]         retired,
  output logic                halted,
  output logic                error,
  input  logic [4:0]          dbg_raddr,
  output logic [XLEN-1:0]     dbg_rdata
);

  localparam int              AW         = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [XLEN-1:0] RESET_PC_V = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] DEPTH_V    = XLEN'(IMEM_DEPTH);
  localparam bit              TO_EN      = (TIMEOUT > 0);
  localparam logic [31:0]     TO_LAST    = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_WB = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic [XLEN-1:0]   dpc_reg, dpc_next;
  logic [XLEN-1:0]   op1_reg, op1_next, op2_reg, op2_next;
  logic              dec_start_reg, dec_start_next, ex_start_reg, ex_start_next;
  logic [31:0]       wait_reg, wait_next;
  logic [4:0]        wb_rd_reg, wb_rd_next;
  logic              wb_we_reg, wb_we_next, wb_branch_reg, wb_branch_next;
  logic [XLEN-1:0]   wb_result_reg, wb_result_next, wb_target_reg, wb_target_next;
  logic [31:0]       retired_reg, retired_next;

  // Always 32 entries so any 5-bit index is in range; entries that are x0
  // or beyond NREG are never written and therefore always read as zero.
  logic [XLEN-1:0]   rf [32];
  logic              rf_we;
  logic [XLEN-1:0]   wb_next_pc;
  logic              timed_out;

  assign rf_we      = (state_reg == S_WB) && wb_we_reg;
  assign wb_next_pc = wb_branch_reg ? wb_target_reg : pc_reg + XLEN'(1);
  // Expiry is the TIMEOUT-th waiting cycle; a done in that cycle still wins.
  assign timed_out  = TO_EN && (wait_reg == TO_LAST);

  for (genvar gi = 0; gi < 32; gi++) begin : g_rf
    localparam bit WRITABLE = (gi != 0) && (gi < NREG);
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rf[gi] <= '0;
      end else if (WRITABLE && rf_we && (wb_rd_reg == 5'(gi))) begin
        rf[gi] <= wb_result_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    dpc_next       = dpc_reg;
    op1_next       = op1_reg;
    op2_next       = op2_reg;
    dec_start_next = 1'b0;
    ex_start_next  = 1'b0;
    wait_next      = wait_reg;
    wb_rd_next     = wb_rd_reg;
    wb_we_next     = wb_we_reg;
    wb_result_next = wb_result_reg;
    wb_branch_next = wb_branch_reg;
    wb_target_next = wb_target_reg;
    retired_next   = retired_reg;
    case (state_reg)
      S_IDLE: begin
        if (run || step) state_next = S_FETCH;
      end
      S_FETCH: begin
        instr_next     = bus.imem_data;
        dpc_next       = pc_reg;
        dec_start_next = 1'b1;
        wait_next      = '0;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        if (bus.dec_done) begin
          op1_next      = rf[bus.dec_rs1];
          op2_next      = rf[bus.dec_rs2];
          ex_start_next = 1'b1;
          wait_next     = '0;
          state_next    = S_EXEC;
        end else if (timed_out) begin
          state_next = S_ERR;
        end else begin
          wait_next = wait_reg + 32'd1;
        end
      end
      S_EXEC: begin
        if (bus.ex_done) begin
          wb_rd_next     = bus.ex_rd;
          wb_we_next     = bus.ex_we;
          wb_result_next = bus.ex_result;
          wb_branch_next = bus.ex_branch;
          wb_target_next = bus.ex_target;
          state_next     = S_WB;
        end else if (timed_out) begin
          state_next = S_ERR;
        end else begin
          wait_next = wait_reg + 32'd1;
        end
      end
      S_WB: begin
        pc_next      = wb_next_pc;
        retired_next = retired_reg + 32'd1;
        if (wb_next_pc >= DEPTH_V) state_next = S_HALT;
        else if (run)              state_next = S_FETCH;
        else                       state_next = S_IDLE;
      end
      default: state_next = state_reg;  // HALT / ERR hold until reset
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg        <= RESET_PC_V;
      instr_reg     <= '0;
      dpc_reg       <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      dec_start_reg <= 1'b0;
      ex_start_reg  <= 1'b0;
      wait_reg      <= '0;
      wb_rd_reg     <= '0;
      wb_we_reg     <= 1'b0;
      wb_result_reg <= '0;
      wb_branch_reg <= 1'b0;
      wb_target_reg <= '0;
      retired_reg   <= '0;
    end else begin
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      dpc_reg       <= dpc_next;
      op1_reg       <= op1_next;
      op2_reg       <= op2_next;
      dec_start_reg <= dec_start_next;
      ex_start_reg  <= ex_start_next;
      wait_reg      <= wait_next;
      wb_rd_reg     <= wb_rd_next;
      wb_we_reg     <= wb_we_next;
      wb_result_reg <= wb_result_next;
      wb_branch_reg <= wb_branch_next;
      wb_target_reg <= wb_target_next;
      retired_reg   <= retired_next;
    end
  end

  assign bus.imem_addr  = pc_reg[AW-1:0];
  assign bus.dec_start  = dec_start_reg;
  assign bus.dec_instr  = instr_reg;
  assign bus.dec_pc     = dpc_reg;
  assign bus.ex_start   = ex_start_reg;
  assign bus.ex_rs1_val = op1_reg;
  assign bus.ex_rs2_val = op2_reg;
  assign pc_out         = pc_reg;
  assign state_out      = state_reg;
  assign retired        = retired_reg;
  assign halted         = (state_reg == S_HALT);
  assign error          = (state_reg == S_ERR);
  assign dbg_rdata      = rf[dbg_raddr];

endmodule
